// File: rtl/fetch_align_if.sv
// fetch_align_if: fetch-side word bus, redirect and aligned
// instruction output of the fetch aligner.
interface fetch_align_if;
  logic [31:0] FetchPC;
  logic        FetchValid;
  logic [31:0] FetchData;
  logic        FetchReady;
  logic        Flush;
  logic [31:0] FlushPC;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        IsCompressed;
  logic        InstrValid;
  logic        InstrReady;

  modport master (
    input  FetchPC,
    input  FetchReady,
    input  Instr,
    input  InstrPC,
    input  IsCompressed,
    input  InstrValid,
    output FetchValid,
    output FetchData,
    output Flush,
    output FlushPC,
    output InstrReady
  );

  modport slave (
    output FetchPC,
    output FetchReady,
    output Instr,
    output InstrPC,
    output IsCompressed,
    output InstrValid,
    input  FetchValid,
    input  FetchData,
    input  Flush,
    input  FlushPC,
    input  InstrReady
  );
endinterface

// File: rtl/fetch_align.sv
// fetch_align: word fetch to instruction aligner; define RVC_EN
// to split 16-bit compressed encodings out of fetched words.
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_align_if.slave bus
);
  logic [31:0] fetch_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_c;
  logic        out_free;
  logic        fetch_ready;
  logic        accept;
  logic        emit;
  logic [31:0] emit_instr;
  logic [31:0] emit_pc;
  logic        emit_c;

  assign out_free = !out_valid || bus.InstrReady;
  assign accept   = bus.FetchValid && fetch_ready;

`ifdef RVC_EN
  typedef enum logic {EMPTY, HALF} state_t;
  state_t      state;
  logic        skip_lo;
  logic [15:0] residue;
  logic [31:0] res_pc;
  logic        res_full;
  logic        unused;

  assign unused   = bus.FlushPC[0];
  // residue always sits in the upper half of the word just fetched
  assign res_pc   = fetch_pc - 32'd2;
  assign res_full = residue[1:0] == 2'b11;

  always_comb begin
    fetch_ready = 1'b0;
    emit        = 1'b0;
    emit_instr  = '0;
    emit_pc     = '0;
    emit_c      = 1'b0;
    if (!bus.Flush) begin
      unique case (state)
        EMPTY: begin
          fetch_ready = skip_lo || out_free;
          emit    = bus.FetchValid && out_free && !skip_lo;
          emit_pc = fetch_pc;
          if (bus.FetchData[1:0] == 2'b11) begin
            emit_instr = bus.FetchData;
          end else begin
            emit_instr = {16'h0, bus.FetchData[15:0]};
            emit_c     = 1'b1;
          end
        end
        HALF: begin
          emit_pc = res_pc;
          if (res_full) begin
            fetch_ready = out_free;
            emit        = bus.FetchValid && out_free;
            emit_instr  = {bus.FetchData[15:0], residue};
          end else begin
            emit       = out_free;
            emit_instr = {16'h0, residue};
            emit_c     = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      skip_lo <= 1'b0;
      residue <= '0;
    end else if (bus.Flush) begin
      state   <= EMPTY;
      skip_lo <= bus.FlushPC[1];
    end else if (accept) begin
      residue <= bus.FetchData[31:16];
      skip_lo <= 1'b0;
      if (state == EMPTY &&
          (skip_lo || bus.FetchData[1:0] != 2'b11))
        state <= HALF;
    end else if (state == HALF && !res_full && out_free) begin
      state <= EMPTY;
    end
  end
`else
  logic unused;

  assign unused = ^bus.FlushPC[1:0];

  always_comb begin
    fetch_ready = !bus.Flush && out_free;
    emit        = !bus.Flush && out_free && bus.FetchValid;
    emit_instr  = bus.FetchData;
    emit_pc     = fetch_pc;
    emit_c      = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      out_c     <= 1'b0;
    end else if (bus.Flush) begin
      fetch_pc  <= {bus.FlushPC[31:2], 2'b00};
      out_valid <= 1'b0;
    end else begin
      if (accept)
        fetch_pc <= fetch_pc + 32'd4;
      if (emit) begin
        out_valid <= 1'b1;
        out_instr <= emit_instr;
        out_pc    <= emit_pc;
        out_c     <= emit_c;
      end else if (bus.InstrReady) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.FetchPC      = fetch_pc;
  assign bus.FetchReady   = fetch_ready;
  assign bus.Instr        = out_instr;
  assign bus.InstrPC      = out_pc;
  assign bus.IsCompressed = out_c;
  assign bus.InstrValid   = out_valid;
endmodule
